result_requant: RTL

RESULT_REQUANT -- requirements
Module: result_requant

---
 rtl/npu_pkg.sv | 21 ++
 rtl/requant_lane.sv | 43 ++++
 rtl/result_requant.sv | 120 ++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared sizing constants and FSM state encoding for the NPU result path.
package npu_pkg;

  localparam int DIM   = 4;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t EMIT = 2'd2;

  // Counter add that sticks at 31 instead of wrapping.
  function automatic logic [4:0] sat_add5(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One-element requantiser: optional ReLU, round-half-up, arithmetic right shift,
// saturation to the signed OUT_W range with a flag when clamping occurred.
module requant_lane #(
  parameter int ACC_W = npu_pkg::ACC_W,
  parameter int OUT_W = npu_pkg::OUT_W
) (
  input  logic [ACC_W-1:0] x,
  input  logic [3:0]       shift,
  input  logic             relu_en,
  output logic [OUT_W-1:0] y,
  output logic             sat
);
  import npu_pkg::*;

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shf;

  // One extra bit of headroom so the rounding bias cannot overflow.
  always_comb begin
    ext  = (relu_en && x[ACC_W-1]) ? '0 : $signed({x[ACC_W-1], x});
    bias = '0;
    if (shift != 4'd0) begin
      bias[shift - 4'd1] = 1'b1;
    end
    rnd = ext + bias;
    shf = rnd >>> shift;
    y   = shf[OUT_W-1:0];
    sat = 1'b0;
    if (shf > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (shf < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/result_requant.sv
// Captures a DIMxDIM accumulator matrix and streams it out row by row,
// requantised to OUT_W bits, over a valid/ready interface.
module result_requant #(
  parameter int DIM   = npu_pkg::DIM,
  parameter int ACC_W = npu_pkg::ACC_W,
  parameter int OUT_W = npu_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIM*DIM*ACC_W-1:0] c_in,
  input  logic                     c_valid,
  input  logic [3:0]               shift,
  input  logic                     relu_en,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DIM*OUT_W-1:0]     m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic [4:0]               sat_cnt,
  output logic                     drop_err
);
  import npu_pkg::*;

  localparam int ROW_W = DIM * ACC_W;
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DIM - 1);

  state_t                   state;
  logic [DIM*DIM*ACC_W-1:0] mat_q;
  logic [3:0]               shift_q;
  logic                     relu_q;
  logic [IDX_W-1:0]         row_idx;
  logic [ROW_W-1:0]         row_sel;
  logic [DIM*OUT_W-1:0]     row_out;
  logic [DIM-1:0]           row_sat;
  logic [4:0]               row_sat_cnt;
  logic                     accept;
  logic                     load_row;

  // row_idx always points at the next row to be computed; element (i,j) of
  // the flat matrix sits at index (i*DIM+j)*ACC_W.
  assign row_sel  = mat_q[int'(row_idx) * ROW_W +: ROW_W];
  assign accept   = m_valid && m_ready;
  assign load_row = (state == LOAD) || ((state == EMIT) && accept && !m_last);

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    requant_lane #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .x      (row_sel[j*ACC_W +: ACC_W]),
      .shift  (shift_q),
      .relu_en(relu_q),
      .y      (row_out[j*OUT_W +: OUT_W]),
      .sat    (row_sat[j])
    );
  end

  always_comb begin
    row_sat_cnt = '0;
    for (int j = 0; j < DIM; j++) begin
      row_sat_cnt = row_sat_cnt + 5'(row_sat[j]);
    end
  end

  // Capture only from IDLE; the final-row handshake leaves state in EMIT for
  // that edge, so a coincident c_valid is dropped rather than chained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mat_q    <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      row_idx  <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      busy     <= 1'b0;
      sat_cnt  <= '0;
      drop_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c_valid) begin
            mat_q   <= c_in;
            shift_q <= shift;
            relu_q  <= relu_en;
            row_idx <= '0;
            sat_cnt <= '0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: state <= EMIT;
        EMIT: begin
          if (accept && m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_row) begin
        m_data  <= row_out;
        m_last  <= (row_idx == LAST_ROW);
        m_valid <= 1'b1;
        row_idx <= row_idx + IDX_W'(1);
        sat_cnt <= sat_add5(sat_cnt, row_sat_cnt);
      end

      if (c_valid && (state != IDLE)) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule
